// File: rtl/adder_bist_sequencer.sv
// Exhaustive BIST sequencer for a WIDTH-bit adder: sweeps {c0,a,b}, counts mismatches.
// Optional first-failure capture is enabled by defining ADDER_BIST_FAIL_LOG_EN.
module adder_bist_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic [WIDTH-1:0]   dut_a_o,
    output logic [WIDTH-1:0]   dut_b_o,
    output logic               dut_c0_o,
    input  logic [WIDTH-1:0]   dut_s_i,
    input  logic               dut_cout_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [2*WIDTH+1:0] err_cnt_o,
    output logic [2*WIDTH:0]   fail_vec_o,
    output logic [WIDTH:0]     fail_rsp_o
);

    localparam int unsigned VecW = 2 * WIDTH + 1;
    localparam int unsigned CntW = 2 * WIDTH + 2;
    localparam int unsigned RspW = WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [VecW-1:0] idx_q, idx_d;
    logic [CntW-1:0] err_cnt_q, err_cnt_d;
    logic [RspW-1:0] golden, actual;
    logic            mismatch;
    logic            start_accept;

    assign golden = {1'b0, idx_q[2*WIDTH-1:WIDTH]} + {1'b0, idx_q[WIDTH-1:0]}
                  + RspW'(idx_q[2*WIDTH]);
    assign actual       = {dut_cout_i, dut_s_i};
    assign mismatch     = (actual != golden);
    assign start_accept = (state_q != StRun) && start_i;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d   = StRun;
                    idx_d     = '0;
                    err_cnt_d = '0;
                end
            end
            StRun: begin
                idx_d = idx_q + VecW'(1);
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + CntW'(1);
                end
                if (&idx_q) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef ADDER_BIST_FAIL_LOG_EN
    logic [VecW-1:0] fail_vec_q, fail_vec_d;
    logic [RspW-1:0] fail_rsp_q, fail_rsp_d;

    // A zero error count means no mismatch has been captured yet in this sweep.
    always_comb begin
        fail_vec_d = fail_vec_q;
        fail_rsp_d = fail_rsp_q;
        if (start_accept) begin
            fail_vec_d = '0;
            fail_rsp_d = '0;
        end else if ((state_q == StRun) && mismatch && (err_cnt_q == '0)) begin
            fail_vec_d = idx_q;
            fail_rsp_d = actual;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_vec_q <= '0;
            fail_rsp_q <= '0;
        end else begin
            fail_vec_q <= fail_vec_d;
            fail_rsp_q <= fail_rsp_d;
        end
    end

    assign fail_vec_o = fail_vec_q;
    assign fail_rsp_o = fail_rsp_q;
`else
    assign fail_vec_o = '0;
    assign fail_rsp_o = '0;
`endif

    assign dut_b_o   = idx_q[WIDTH-1:0];
    assign dut_a_o   = idx_q[2*WIDTH-1:WIDTH];
    assign dut_c0_o  = idx_q[2*WIDTH];
    assign busy_o    = (state_q == StRun);
    assign done_o    = (state_q == StDone);
    assign pass_o    = done_o && (err_cnt_q == '0);
    assign err_cnt_o = err_cnt_q;

endmodule
